// File: rtl/lfsr_behavioral.sv
// Maximal-length Fibonacci LFSR with an unsigned threshold compare for stochastic bit generation.
// prob_bit is combinational from the state (zero latency); no flow control, state advances every clk.
module lfsr_behavioral #(
  parameter int n = 7
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [n-1:0] seed,
  input  logic [n-1:0] probability,
  output logic         prob_bit
);

  // Tap masks hold bit (tap-1) for each tap of the XAPP052 polynomial of that width.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  generate
    if (n < 3 || n > 32) begin : g_bad_width
      $error("lfsr_behavioral: n=%0d is outside the supported range 3..32", n);
    end
  endgenerate

  localparam logic [31:0] TAP_MASK = tap_mask(n);

  logic [n-1:0] r_state;
  logic [n-1:0] w_taps;
  logic [n-1:0] w_load;
  logic         w_fb;

  assign w_taps = TAP_MASK[n-1:0];

  // An all-zero seed would lock the XOR feedback, so it is replaced by all-ones.
  assign w_load = (seed == '0) ? '1 : seed;
  assign w_fb   = ^(r_state & w_taps);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= w_load;
    end else begin
      r_state <= {r_state[n-2:0], w_fb};
    end
  end

  assign prob_bit = (r_state < probability);

endmodule

// File: tb/tb_lfsr_behavioral.sv
// Randomized scoreboard bench for lfsr_behavioral: n=7 sequence/reset/duty checks plus a full-period width sweep.
module tb_lfsr_behavioral;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference next-state: shift left, feed back the parity of the polynomial tap positions.
  function automatic logic [31:0] lfsr_next(input int w, input logic [31:0] s);
    int         t[4];
    logic       fb;
    logic [31:0] mask;
    case (w)
      3:       t = '{3, 2, 0, 0};
      4:       t = '{4, 3, 0, 0};
      7:       t = '{7, 6, 0, 0};
      8:       t = '{8, 6, 5, 4};
      16:      t = '{16, 15, 13, 4};
      default: t = '{0, 0, 0, 0};
    endcase
    fb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (t[k] > 0) fb = fb ^ s[t[k]-1];
    end
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return ((s << 1) | {31'b0, fb}) & mask;
  endfunction

  // ---------------- n = 7 instance with scoreboard ----------------
  logic       rst_b7 = 1'b1;
  logic [6:0] seed7  = 7'h4F;
  logic [6:0] prob7  = 7'h2A;
  logic       prob_bit7;

  lfsr_behavioral #(.n(7)) u7 (
    .clk         (clk),
    .rst_b       (rst_b7),
    .seed        (seed7),
    .probability (prob7),
    .prob_bit    (prob_bit7)
  );

  typedef struct packed {
    logic [6:0] st;
    logic       pb;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [6:0] m_state = 7'h0;
  logic [6:0] obs_state;
  logic       obs_pb;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_state", {25'b0, u7.r_state}, {25'b0, mon_e.st});
      check("sb_prob_bit", {31'b0, prob_bit7}, {31'b0, mon_e.pb});
    end
  end

  task automatic step7(input logic [6:0] p);
    @(posedge clk);
    #1;
    m_state = lfsr_next(7, {25'b0, m_state}) & 32'h7F;
    prob7 = p;
    sb_q.push_back(exp_t'({m_state, (m_state < p)}));
    #2;
    obs_state = u7.r_state;
    obs_pb    = prob_bit7;
  endtask

  // Reset asserted between edges; the scoreboard sample at the following negedge sees no clock edge.
  task automatic do_reset7(input logic [6:0] s);
    @(posedge clk);
    #2;
    seed7   = s;
    rst_b7  = 1'b0;
    m_state = (s == 7'h0) ? 7'h7F : s;
    #1;
    sb_q.push_back(exp_t'({m_state, (m_state < prob7)}));
    @(negedge clk);
    #2;
    rst_b7 = 1'b1;
  endtask

  task automatic period7(input logic [6:0] p);
    int         seen[128];
    int         hi;
    int         bad;
    int         exp_hi;
    logic [6:0] s0;
    s0 = m_state;
    hi = 0;
    for (int k = 0; k < 128; k++) seen[k] = 0;
    for (int i = 0; i < 127; i++) begin
      step7(p);
      seen[obs_state]++;
      hi += int'(obs_pb);
    end
    bad = 0;
    for (int k = 1; k < 128; k++) if (seen[k] != 1) bad++;
    exp_hi = (p == 7'h0) ? 0 : int'(p) - 1;
    check("period_return", {25'b0, obs_state}, {25'b0, s0});
    check("zero_never", seen[0], 0);
    check("all_states_once", bad, 0);
    check($sformatf("duty_p%0h", p), hi, exp_hi);
  endtask

  // ---------------- width sweep instances ----------------
  logic sw_rst_b = 1'b1;
  int   sw_done  = 0;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
    logic [W-1:0] sd = W'(g + 1);
    logic [W-1:0] pr = '1;
    logic         pb;

    lfsr_behavioral #(.n(W)) u (
      .clk         (clk),
      .rst_b       (sw_rst_b),
      .seed        (sd),
      .probability (pr),
      .prob_bit    (pb)
    );

    initial begin
      int           len;
      int           hi;
      int           zeros;
      logic [W-1:0] first;
      @(negedge sw_rst_b);
      @(posedge sw_rst_b);
      len   = 0;
      hi    = 0;
      zeros = 0;
      first = '0;
      for (int i = 0; i < (1 << W) + 2; i++) begin
        @(posedge clk);
        #1;
        len++;
        if (len == 1) first = u.r_state;
        if (u.r_state == '0) zeros++;
        hi += int'(pb);
        if (u.r_state == sd) break;
      end
      check($sformatf("w%0d_first", W), 32'(first), lfsr_next(W, 32'(sd)));
      check($sformatf("w%0d_period", W), len, (1 << W) - 1);
      check($sformatf("w%0d_zero", W), zeros, 0);
      check($sformatf("w%0d_duty_max", W), hi, (1 << W) - 2);
      sw_done++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset7(7'h4F);
    for (int i = 0; i < 4; i++) step7(7'h2A);

    // Random thresholds each cycle; seed changes after release must be ignored.
    for (int i = 0; i < 40; i++) begin
      seed7 = 7'($urandom_range(0, 127));
      step7(7'($urandom_range(0, 127)));
    end

    period7(7'h2A);
    period7(7'h00);
    period7(7'h7F);

    do_reset7(7'h4F);
    for (int i = 0; i < 20; i++) step7(7'($urandom_range(0, 127)));
    do_reset7(7'h4F);
    step7(7'h2A);
    check("restart_after_midrun_reset", {25'b0, obs_state}, 32'h1F);

    prob7 = 7'h50;
    do_reset7(7'h00);
    step7(7'h7F);
    check("zero_seed_successor", {25'b0, obs_state}, 32'h7E);

    @(posedge clk);
    #2;
    sw_rst_b = 1'b0;
    @(negedge clk);
    #2;
    sw_rst_b = 1'b1;
    for (int i = 0; i < 70000 && sw_done < 4; i++) @(posedge clk);
    check("sweep_done", sw_done, 4);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
